// File: rtl/can_ifc_wb_wide.sv
// Wishbone classic slave (8/16/32-bit) to byte-wide CAN register-file bridge.
// Latency: write ack at cycle n+1, read ack at cycle 2n+1 (n = selected lanes), sel==0 ack at cycle 1.
// Backpressure: the Wishbone cycle is held until ack/err; dropping wb_cyc_i aborts with no further strobes.
//
// Ports:
//   clk_i, rst_n_i            clock, async active-low reset
//   wb_cyc_i/stb_i/we_i       Wishbone classic controls
//   wb_adr_i [ADDR_W]         word address; byte address = wb_adr_i*L + lane (mod 256)
//   wb_sel_i [L]              byte-lane selects, little-endian
//   wb_dat_i / wb_dat_o       write data / registered read data
//   wb_ack_o / wb_err_o       cycle termination
//   reg_rst_o                 active-high register-file reset
//   reg_re_o / reg_we_o       one-cycle byte read / write strobes
//   reg_addr_o, reg_data_in_o byte address and byte write data (registered)
//   reg_data_out_i            byte read data, valid one cycle after reg_re_o
// Optional feature: define CAN_IFC_WB_ERR_EN to terminate accesses with
// wb_adr_i*L >= 256 with wb_err_o instead of aliasing them.
module can_ifc_wb_wide #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_W-1:0]     wb_adr_i,
  input  logic [DATA_W/8-1:0]   wb_sel_i,
  input  logic [DATA_W-1:0]     wb_dat_i,
  output logic [DATA_W-1:0]     wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  reg_rst_o,
  output logic                  reg_re_o,
  output logic                  reg_we_o,
  output logic [7:0]            reg_addr_o,
  output logic [7:0]            reg_data_in_o,
  input  logic [7:0]            reg_data_out_i
);

  localparam int L   = DATA_W / 8;
  localparam int LSH = $clog2(L);
  localparam int LB  = (L > 1) ? LSH : 1;

  typedef enum logic [1:0] {IDLE, RUN, RDWAIT, DONE} state_t;

  state_t              state_q;
  logic                we_q;
  logic [L-1:0]        pend_q;     // selected lanes not yet issued
  logic [LB-1:0]       lane_q;     // lane currently being strobed
  logic [7:0]          base_q;     // byte address of lane 0
  logic [DATA_W-1:0]   dat_q;
  logic [DATA_W-1:0]   rbuf_q;
  logic [DATA_W-1:0]   wb_dat_q;
  logic                ack_q;
  logic                err_q;
  logic [7:0]          addr_q;
  logic [7:0]          data_q;

  logic [L-1:0]        mask_d;
  logic [LB-1:0]       lane_d;
  logic [L-1:0]        rest_d;
  logic [7:0]          base_d;
  logic [DATA_W-1:0]   dat_src_d;
  logic [7:0]          byte_d;
  logic [DATA_W-1:0]   rbuf_d;
  logic                acc_err_d;

  // Lane selection works on the live request in IDLE and on the remaining
  // mask afterwards, so the address/data registers are loaded on the same
  // edge that enters RUN and are valid for the whole strobe cycle.
  always_comb begin
    mask_d    = (state_q == IDLE) ? wb_sel_i : pend_q;
    lane_d    = '0;
    for (int k = L - 1; k >= 0; k--) begin
      if (mask_d[k]) lane_d = LB'(k);
    end
    rest_d    = mask_d & ~(L'(1) << lane_d);
    base_d    = (state_q == IDLE) ? 8'(32'(wb_adr_i) << LSH) : base_q;
    dat_src_d = (state_q == IDLE) ? wb_dat_i : dat_q;
    byte_d    = dat_src_d[int'(lane_d)*8 +: 8];
    rbuf_d    = rbuf_q;
    rbuf_d[int'(lane_q)*8 +: 8] = reg_data_out_i;
`ifdef CAN_IFC_WB_ERR_EN
    acc_err_d = (32'(wb_adr_i) << LSH) >= 32'd256;
`else
    acc_err_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      pend_q   <= '0;
      lane_q   <= '0;
      base_q   <= '0;
      dat_q    <= '0;
      rbuf_q   <= '0;
      wb_dat_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            we_q   <= wb_we_i;
            dat_q  <= wb_dat_i;
            base_q <= base_d;
            rbuf_q <= '0;
            if (acc_err_d) begin
              pend_q  <= '0;
              err_q   <= 1'b1;
              state_q <= DONE;
            end else if (wb_sel_i == '0) begin
              // Empty read completes with all lanes unselected, i.e. zero.
              pend_q  <= '0;
              ack_q   <= 1'b1;
              if (!wb_we_i) wb_dat_q <= '0;
              state_q <= DONE;
            end else begin
              lane_q  <= lane_d;
              pend_q  <= rest_d;
              addr_q  <= base_d + 8'(lane_d);
              if (wb_we_i) data_q <= byte_d;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (!wb_cyc_i) begin
            pend_q  <= '0;
            state_q <= IDLE;
          end else if (!we_q) begin
            state_q <= RDWAIT;
          end else if (pend_q == '0) begin
            ack_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            lane_q <= lane_d;
            pend_q <= rest_d;
            addr_q <= base_q + 8'(lane_d);
            data_q <= byte_d;
          end
        end
        RDWAIT: begin
          if (!wb_cyc_i) begin
            pend_q  <= '0;
            state_q <= IDLE;
          end else begin
            rbuf_q <= rbuf_d;
            if (pend_q == '0) begin
              wb_dat_q <= rbuf_d;
              ack_q    <= 1'b1;
              state_q  <= DONE;
            end else begin
              lane_q  <= lane_d;
              pend_q  <= rest_d;
              addr_q  <= base_q + 8'(lane_d);
              state_q <= RUN;
            end
          end
        end
        default: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Strobes decode the registered state; qualifying with wb_cyc_i makes an
  // abort take effect in the very cycle the master lets go of the bus.
  assign reg_we_o      = (state_q == RUN) &&  we_q && wb_cyc_i;
  assign reg_re_o      = (state_q == RUN) && !we_q && wb_cyc_i;
  assign reg_addr_o    = addr_q;
  assign reg_data_in_o = data_q;
  assign reg_rst_o     = ~rst_n_i;
  assign wb_dat_o      = wb_dat_q;
  assign wb_ack_o      = ack_q;
  assign wb_err_o      = err_q;

endmodule

// File: tb/tb_can_ifc_wb_wide.sv
module tb_can_ifc_wb_wide;

  logic        clk;
  logic        rst_n;
  logic        wb_cyc, wb_stb, wb_we;
  logic [7:0]  wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic        wb_ack, wb_err, reg_rst, reg_re, reg_we;
  logic [7:0]  reg_addr, reg_din, reg_dout;

  int errors = 0;
  int checks = 0;

  can_ifc_wb_wide #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_adr_i(wb_adr), .wb_sel_i(wb_sel), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack), .wb_err_o(wb_err),
    .reg_rst_o(reg_rst), .reg_re_o(reg_re), .reg_we_o(reg_we),
    .reg_addr_o(reg_addr), .reg_data_in_o(reg_din), .reg_data_out_i(reg_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte register file: preloaded while in reset, read data one cycle after reg_re.
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h00] <= 8'h01; mem[8'h01] <= 8'h02;
      mem[8'h02] <= 8'h03; mem[8'h03] <= 8'h04;
      mem[8'h14] <= 8'h11; mem[8'h15] <= 8'h22; mem[8'h16] <= 8'h33;
      reg_dout   <= 8'h00;
    end else begin
      if (reg_we) mem[reg_addr] <= reg_din;
      if (reg_re) reg_dout <= mem[reg_addr];
    end
  end

  typedef struct {
    logic        we;
    logic [7:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          term;   // cycle of ack/err
    logic        err;
    int          nstb;
    logic [7:0]  a0;     // first strobe address
    logic [7:0]  a1;     // last strobe address
    logic [7:0]  d0;     // first write byte
    logic [31:0] dout;   // wb_dat_o at termination
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int k, term_k, nstb;
    logic got_err, both;
    logic [7:0] a0, a1, d0;
    term_k = -1; nstb = 0; got_err = 1'b0; both = 1'b0;
    a0 = 8'h00; a1 = 8'h00; d0 = 8'h00;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = v.we;
    wb_adr = v.adr; wb_sel = v.sel; wb_dat_i = v.dat;
    @(posedge clk);
    k = 0;
    while (term_k < 0 && k < 40) begin
      @(negedge clk);
      k++;
      if (reg_we && reg_re) both = 1'b1;
      if (reg_we || reg_re) begin
        if (nstb == 0) begin a0 = reg_addr; d0 = reg_din; end
        a1 = reg_addr;
        nstb++;
      end
      if (wb_ack || wb_err) begin
        term_k  = k;
        got_err = wb_err;
        chk({tag, " dout"}, wb_dat_o, v.dout);
        wb_cyc = 1'b0; wb_stb = 1'b0;
      end
    end
    chk({tag, " term_cycle"}, term_k, v.term);
    chk({tag, " err"}, {31'b0, got_err}, {31'b0, v.err});
    chk({tag, " nstb"}, nstb, v.nstb);
    chk({tag, " we_and_re"}, {31'b0, both}, 32'd0);
    if (v.nstb > 0) begin
      chk({tag, " first_addr"}, {24'b0, a0}, {24'b0, v.a0});
      chk({tag, " last_addr"}, {24'b0, a1}, {24'b0, v.a1});
      if (v.we) chk({tag, " first_data"}, {24'b0, d0}, {24'b0, v.d0});
    end
    @(negedge clk);
    chk({tag, " term_one_cycle"}, {30'b0, wb_ack, wb_err}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ack"}, {31'b0, wb_ack}, 32'd0);
    chk({tag, " err"}, {31'b0, wb_err}, 32'd0);
    chk({tag, " re_we"}, {30'b0, reg_re, reg_we}, 32'd0);
    chk({tag, " dat_o"}, wb_dat_o, 32'd0);
    chk({tag, " reg_addr"}, {24'b0, reg_addr}, 32'd0);
    chk({tag, " reg_din"}, {24'b0, reg_din}, 32'd0);
    chk({tag, " reg_rst"}, {31'b0, reg_rst}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acks, ack1, ack2, nstb;
    vec_t v;

    //           we    adr    sel    dat            term err  n  a0     a1     d0     dout
    vecs[0] = '{1'b1, 8'h03, 4'hF, 32'hDDCCBBAA, 5, 1'b0, 4, 8'h0C, 8'h0F, 8'hAA, 32'h00000000};
    vecs[1] = '{1'b0, 8'h05, 4'h5, 32'h0,        5, 1'b0, 2, 8'h14, 8'h16, 8'h00, 32'h00330011};
    vecs[2] = '{1'b1, 8'h07, 4'h0, 32'hCAFEF00D, 1, 1'b0, 0, 8'h00, 8'h00, 8'h00, 32'h00330011};
    vecs[3] = '{1'b0, 8'h03, 4'hF, 32'h0,        9, 1'b0, 4, 8'h0C, 8'h0F, 8'h00, 32'hDDCCBBAA};
    vecs[4] = '{1'b1, 8'h10, 4'hA, 32'h12345678, 3, 1'b0, 2, 8'h41, 8'h43, 8'h56, 32'hDDCCBBAA};
    vecs[5] = '{1'b0, 8'h10, 4'hF, 32'h0,        9, 1'b0, 4, 8'h40, 8'h43, 8'h00, 32'h12005600};
    vecs[6] = '{1'b0, 8'h10, 4'h2, 32'h0,        3, 1'b0, 1, 8'h41, 8'h41, 8'h00, 32'h00005600};
`ifdef CAN_IFC_WB_ERR_EN
    vecs[7] = '{1'b0, 8'h40, 4'hF, 32'h0,        1, 1'b1, 0, 8'h00, 8'h00, 8'h00, 32'h00005600};
`else
    vecs[7] = '{1'b0, 8'h40, 4'hF, 32'h0,        9, 1'b0, 4, 8'h00, 8'h03, 8'h00, 32'h04030201};
`endif
    vecs[8] = '{1'b0, 8'h00, 4'h0, 32'h0,        1, 1'b0, 0, 8'h00, 8'h00, 8'h00, 32'h00000000};

    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_adr = 8'h00; wb_sel = 4'h0; wb_dat_i = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // wb_stb held through the IDLE cycle after DONE starts a second transfer.
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_adr = 8'h20; wb_sel = 4'h1; wb_dat_i = 32'h00000077;
    @(posedge clk);
    acks = 0; ack1 = -1; ack2 = -1; nstb = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (reg_we || reg_re) nstb++;
      if (wb_ack) begin
        acks++;
        if (acks == 1) ack1 = k;
        else begin ack2 = k; wb_cyc = 1'b0; wb_stb = 1'b0; end
      end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    chk("b2b first_ack", ack1, 2);
    chk("b2b second_ack", ack2, 5);
    chk("b2b nstb", nstb, 2);

    // Master abandons a 4-byte write once two bytes have gone out.
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_adr = 8'h03; wb_sel = 4'hF; wb_dat_i = 32'h44332211;
    @(posedge clk);
    acks = 0; nstb = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (reg_we || reg_re) nstb++;
      if (wb_ack || wb_err) acks++;
      if (k == 2) begin
        @(posedge clk);
        #1 wb_cyc = 1'b0; wb_stb = 1'b0;
      end
    end
    chk("abort nstb", nstb, 2);
    chk("abort no_term", acks, 0);
    // Only the first two bytes landed; FSM accepts a fresh read normally.
    v = '{1'b0, 8'h03, 4'hF, 32'h0, 9, 1'b0, 4, 8'h0C, 8'h0F, 8'h00, 32'hDDCC2211};
    run_txn(v, "abort_readback");

    // Reset asserted while waiting for read data.
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
    wb_adr = 8'h05; wb_sel = 4'h5; wb_dat_i = 32'h0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_seq re_cycle1", {31'b0, reg_re}, 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    wb_cyc = 1'b0; wb_stb = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst held_ack", {31'b0, wb_ack}, 32'd0);
    rst_n = 1'b1;
    v = '{1'b0, 8'h05, 4'h5, 32'h0, 5, 1'b0, 2, 8'h14, 8'h16, 8'h00, 32'h00330011};
    run_txn(v, "post_reset_read");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/can_ifc_wb_wide.md
CAN_IFC_WB_WIDE -- requirements
Module: can_ifc_wb_wide

Interface
REQ-001 SHALL have parameter DATA_W, default 32: Wishbone data width, legal values 8, 16 and 32; L = DATA_W/8 byte lanes.
REQ-002 SHALL have parameter ADDR_W, default 8: Wishbone word-address width, minimum 8 - log2(L).
REQ-003 SHALL have port clk_i, in, 1: the single clock for all logic.
REQ-004 SHALL have port rst_n_i, in, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports wb_cyc_i, wb_stb_i and wb_we_i, each in, 1: Wishbone classic slave controls.
REQ-006 SHALL have port wb_adr_i, in, ADDR_W: word address.
REQ-007 SHALL have port wb_sel_i, in, L: byte-lane selects; lane k = data bits [8k+7:8k] (little-endian).
REQ-008 SHALL have ports wb_dat_i, in, DATA_W, and wb_dat_o, out, DATA_W: write data and read data.
REQ-009 SHALL have ports wb_ack_o and wb_err_o, each out, 1: cycle termination.
REQ-010 SHALL have port reg_rst_o, out, 1: active-high register-file reset, equal to ~rst_n_i.
REQ-011 SHALL have ports reg_re_o and reg_we_o, each out, 1: single-cycle byte read and write strobes.
REQ-012 SHALL have ports reg_addr_o and reg_data_in_o, each out, 8: byte address and byte write data.
REQ-013 SHALL have port reg_data_out_i, in, 8: byte read data, valid exactly 1 cycle after reg_re_o.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, RDWAIT and DONE.
REQ-015 In IDLE, when wb_cyc_i & wb_stb_i are high, SHALL latch adr, we, sel and dat (accept cycle = cycle 0), clear the read buffer, and go to RUN; if sel == 0 it SHALL go directly to DONE with no register strobe.
REQ-016 Byte address for lane k SHALL be (wb_adr_i*L + k) modulo 256.
REQ-017 RUN SHALL pick the lowest selected, not-yet-done lane through a same-cycle priority encoder, so unselected lanes cost zero cycles.
REQ-018 RUN write: SHALL pulse reg_we_o for 1 cycle with reg_data_in_o = that lane's byte, then stay in RUN, or go to DONE after the last selected lane.
REQ-019 RUN read: SHALL pulse reg_re_o for 1 cycle and go to RDWAIT; RDWAIT SHALL capture reg_data_out_i into that buffer lane, then go to RUN or DONE.
REQ-020 Latency with n selected lanes: write ack SHALL occur at cycle n+1, read ack at cycle 2n+1, and sel == 0 ack at cycle 1.
REQ-021 reg_we_o and reg_re_o SHALL never both be high, and SHALL issue at most one strobe per cycle.
REQ-022 DONE SHALL assert wb_ack_o for exactly 1 cycle and then return to IDLE.
REQ-023 wb_dat_o SHALL be registered; unselected lanes SHALL read 0; the value SHALL be held until the next read completes; writes SHALL leave it unchanged.
REQ-024 If wb_stb_i is still high in the IDLE cycle after DONE, it SHALL be treated as a new transfer.
REQ-025 If wb_cyc_i drops in RUN or RDWAIT, the FSM SHALL go to IDLE next cycle with no further strobes and no ack/err; bytes already written stay written.
REQ-026 reg_addr_o and reg_data_in_o SHALL be registered and SHALL hold their last value when no strobe is active.

Reset
REQ-027 rst_n_i low SHALL immediately force IDLE, clear the lane tracking and read buffer, and drive wb_ack_o, wb_err_o, reg_re_o and reg_we_o to 0 and wb_dat_o, reg_addr_o and reg_data_in_o to 0.
REQ-028 Reset mid-transfer SHALL abort it without ack/err; after release, the first accepted request SHALL behave as from power-up.

Configuration
REQ-029 SHALL support macro CAN_IFC_WB_ERR_EN.
REQ-030 With CAN_IFC_WB_ERR_EN defined, an access with wb_adr_i*L >= 256 SHALL produce no register strobe and a 1-cycle wb_err_o at cycle 1 in place of wb_ack_o, leaving wb_dat_o unchanged.
REQ-031 Without CAN_IFC_WB_ERR_EN, upper address bits SHALL be ignored (aliasing per REQ-016) and wb_err_o SHALL be tied to 0.

Verification (DATA_W=32, ADDR_W=8)
REQ-032 Write adr=0x03, sel=1111, dat=0xDDCCBBAA -> reg_we_o at cycles 1-4 to addresses 0x0C/0x0D/0x0E/0x0F with data AA/BB/CC/DD; ack at cycle 5.
REQ-033 Read adr=0x05, sel=0101, register file returning 0x11@0x14 and 0x33@0x16 -> reg_re_o at cycles 1 and 3; ack at cycle 5; wb_dat_o=0x00330011.
REQ-034 Any access with sel=0000 -> no strobes; ack at cycle 1; wb_dat_o unchanged for a write.
REQ-035 Write sel=1111 with wb_cyc_i dropped after cycle 2 -> strobes only to 0x0C and 0x0D; no ack; FSM back in IDLE.
REQ-036 With CAN_IFC_WB_ERR_EN, read adr=0x40 -> err at cycle 1, no strobe, no ack; without the macro -> aliases to 0x00-0x03 with a normal ack.
REQ-037 Assert rst_n_i low during RDWAIT -> all outputs 0 asynchronously; after release, a new read completes with correct timing.
